ibex_ibus_arbiter: RTL and testbench

- Shares the single core instruction bus (req/gnt/rvalid protocol) between NUM_REQ fetch requesters, e.g. the prefetch buffer (port 0) and a secondary fetch/debug-ROM requester (port 1).
- Sits between the requesters and the instr_* bus pins.
- Round-robin arbitration, pipelined with up to MAX_OUTSTANDING granted-but-unanswered transactions.
- Responses are routed back in order by an internal requester-ID queue.

---
 rtl/ibex_ibus_arb_pkg.sv | 21 ++
 rtl/ibex_ibus_arbiter_if.sv | 30 +++
 rtl/ibex_ibus_id_fifo.sv | 51 +++++
 rtl/ibex_ibus_arbiter.sv | 136 +++++++++++++
 tb/tb_ibex_ibus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_ibus_arb_pkg.sv
// Shared widths, defaults and ID type for the instruction-bus arbiter.
package ibex_ibus_arb_pkg;

  localparam int unsigned NumReqDefault         = 2;
  localparam int unsigned MaxOutstandingDefault = 2;
  localparam int unsigned AwDefault             = 32;

  function automatic int unsigned id_width(int unsigned num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  localparam int unsigned IdW  = id_width(NumReqDefault);
  localparam int unsigned CntW = cnt_width(MaxOutstandingDefault);

  typedef logic [IdW-1:0] ibus_id_t;

endpackage

// File: rtl/ibex_ibus_arbiter_if.sv
// Requester-side and instr_* bus signals of the arbiter; slave = arbiter view,
// master = surrounding requesters plus bus owner.
interface ibex_ibus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AW      = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] addr;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [31:0]           rdata;
  logic                  err;

  logic                  instr_req;
  logic [AW-1:0]         instr_addr;
  logic                  instr_gnt;
  logic                  instr_rvalid;
  logic [31:0]           instr_rdata;
  logic                  instr_err;

  modport slave (
    input  req, addr, instr_gnt, instr_rvalid, instr_rdata, instr_err,
    output gnt, rvalid, rdata, err, instr_req, instr_addr
  );

  modport master (
    output req, addr, instr_gnt, instr_rvalid, instr_rdata, instr_err,
    input  gnt, rvalid, rdata, err, instr_req, instr_addr
  );
endinterface

// File: rtl/ibex_ibus_id_fifo.sv
// In-order queue of requester IDs for granted-but-unanswered fetches.
// Simultaneous push and pop is accepted even when full (pop frees the slot first).
module ibex_ibus_id_fifo
  import ibex_ibus_arb_pkg::*;
#(
  parameter int unsigned DEPTH = MaxOutstandingDefault,
  parameter type         id_t  = ibus_id_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  id_t  push_id_i,
  input  logic pop_i,
  output id_t  head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LvlW = cnt_width(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [LvlW-1:0] Depth   = LvlW'(DEPTH);

  id_t             mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == Depth);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (do_push & ~do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop & ~do_push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/ibex_ibus_arbiter.sv
// Shares the core instruction bus between NUM_REQ fetch requesters with pipelined grants.
// Round-robin by default; IBEX_IBUS_ARB_FIXED_PRIO_EN selects fixed priority (port 0 highest).
module ibex_ibus_arbiter
  import ibex_ibus_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NumReqDefault,
  parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDefault,
  parameter int unsigned AW              = AwDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ibex_ibus_arbiter_if.slave bus,
  output logic               busy_o,
  output logic               proto_err_o
);
  localparam int unsigned IdWidth  = id_width(NUM_REQ);
  localparam int unsigned CntWidth = cnt_width(MAX_OUTSTANDING);
  typedef logic [IdWidth-1:0] id_t;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_OUTSTANDING);

  logic [CntWidth-1:0] outst_cnt_q;
  logic                lock_q;
  id_t                 lock_id_q;
  id_t                 sel, sel_any, sel_free, head_id;
  logic [AW-1:0]       addr_sel;
  logic                grant, rsp_ok, fifo_full, fifo_empty;

  // Lowest-indexed active requester; iterating downward leaves the lowest index last.
  always_comb begin
    sel_any = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req[i]) sel_any = id_t'(i);
    end
  end

`ifdef IBEX_IBUS_ARB_FIXED_PRIO_EN
  assign sel_free = sel_any;
`else
  localparam id_t LastId = id_t'(NUM_REQ - 1);
  id_t  rr_ptr_q, sel_hi;
  logic found_hi;

  // Prefer requesters at or above rr_ptr; otherwise wrap to the lowest active one.
  always_comb begin
    sel_hi   = '0;
    found_hi = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (bus.req[i] && (id_t'(i) >= rr_ptr_q)) begin
        sel_hi   = id_t'(i);
        found_hi = 1'b1;
      end
    end
  end

  assign sel_free = found_hi ? sel_hi : sel_any;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (sel == LastId) ? '0 : sel + 1'b1;
    end
  end
`endif

  // An ungranted request must keep its address; the stored selection holds it.
  assign sel = lock_q ? lock_id_q : sel_free;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel == id_t'(i)) addr_sel = bus.addr[i*AW +: AW];
    end
  end

  assign bus.instr_req  = rst_ni & (lock_q | ((|bus.req) & (outst_cnt_q < MaxCnt)));
  assign bus.instr_addr = {addr_sel[AW-1:2], 2'b00};
  assign grant          = bus.instr_req & bus.instr_gnt;
  assign rsp_ok         = rst_ni & bus.instr_rvalid & (outst_cnt_q != '0);
  assign bus.rdata      = bus.instr_rdata;
  assign bus.err        = bus.instr_err;
  assign busy_o         = (outst_cnt_q != '0) | bus.instr_req;

  always_comb begin
    bus.gnt    = '0;
    bus.rvalid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.gnt[i]    = grant & (sel == id_t'(i));
      bus.rvalid[i] = rsp_ok & (head_id == id_t'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_cnt_q <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (grant & ~rsp_ok)      outst_cnt_q <= outst_cnt_q + 1'b1;
      else if (rsp_ok & ~grant) outst_cnt_q <= outst_cnt_q - 1'b1;

      if (grant) begin
        lock_q <= 1'b0;
      end else if (bus.instr_req) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end

      if ((bus.instr_rvalid & (outst_cnt_q == '0)) | (grant & fifo_full & ~rsp_ok)) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  ibex_ibus_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .id_t  (id_t)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (grant),
    .push_id_i (sel),
    .pop_i     (rsp_ok),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  lock_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> bus.req[lock_id_q]);

  cnt_tracks_fifo_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (outst_cnt_q == '0) == fifo_empty);

endmodule

// File: tb/tb_ibex_ibus_arbiter.sv
// Self-checking bench for ibex_ibus_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_ibex_ibus_arbiter;
  localparam int N    = 2;
  localparam int MAXO = 2;
  localparam int AW   = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic busy_o, proto_err_o;

  ibex_ibus_arbiter_if #(.NUM_REQ(N), .AW(AW)) bus ();

  ibex_ibus_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .busy_o      (busy_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        perr;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: list of granted requester IDs awaiting a response.
  int mq[$];
  int m_rr;
  bit m_lock;
  int m_lock_id;
  bit m_perr;

  function automatic void m_reset();
    mq.delete();
    m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_perr = 1'b0;
  endfunction

  function automatic int m_sel();
    if (m_lock) return m_lock_id;
    for (int k = 0; k < N; k++) begin
      if (bus.req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return 0;
  endfunction

  function automatic bit m_ireq();
    return rst_ni && (m_lock || (bus.req != 0 && mq.size() < MAXO));
  endfunction

  function automatic obs_t m_exp();
    obs_t e;
    int   s;
    e = '0;
    s = m_sel();
    e.instr_req = m_ireq();
    if (e.instr_req) e.instr_addr = bus.addr[s*AW +: AW] & ~32'h3;
    if (e.instr_req && bus.instr_gnt) e.gnt[s] = 1'b1;
    if (rst_ni && bus.instr_rvalid && mq.size() > 0) e.rvalid[mq[0]] = 1'b1;
    e.rdata = bus.instr_rdata;
    e.err   = bus.instr_err;
    e.busy  = (mq.size() > 0) || e.instr_req;
    e.perr  = m_perr;
    return e;
  endfunction

  function automatic void m_commit();
    int s;
    bit ir;
    if (!rst_ni) begin
      m_reset();
      return;
    end
    s  = m_sel();
    ir = m_ireq();
    if (bus.instr_rvalid) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_perr = 1'b1;
    end
    if (ir && bus.instr_gnt) begin
      mq.push_back(s);
`ifndef IBEX_IBUS_ARB_FIXED_PRIO_EN
      m_rr = (s + 1) % N;
`endif
      m_lock = 1'b0;
    end else if (ir) begin
      m_lock    = 1'b1;
      m_lock_id = s;
    end
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.gnt        = bus.gnt;
    o.rvalid     = bus.rvalid;
    o.instr_req  = bus.instr_req;
    o.instr_addr = bus.instr_req ? bus.instr_addr : 32'h0;
    o.rdata      = bus.rdata;
    o.err        = bus.err;
    o.busy       = busy_o;
    o.perr       = proto_err_o;
    return o;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic g, input logic rv, input logic [31:0] rd, input logic er);
    bus.req          = req;
    bus.addr         = {a1, a0};
    bus.instr_gnt    = g;
    bus.instr_rvalid = rv;
    bus.instr_rdata  = rd;
    bus.instr_err    = er;
    #1;
  endtask

  task automatic tick();
    m_commit();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    m_reset();
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hAAAA_5555, 1'b1);
    e = m_exp(); o = dut_obs(); n_checks++;
    if (o !== e) $display("FAIL reset_model got=%h exp=%h", o, e); else n_pass++;
    n_checks++;
    if ({bus.instr_req, bus.gnt, bus.rvalid} !== 5'b0)
      $display("FAIL reset_forced got=%b exp=00000", {bus.instr_req, bus.gnt, bus.rvalid});
    else n_pass++;
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_ni = 1'b1;
    tick();
    n_checks++;
    if ({busy_o, proto_err_o} !== 2'b00)
      $display("FAIL reset_idle got=%b exp=00", {busy_o, proto_err_o});
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    obs_t e, o;
    for (int c = 0; c < 5; c++) begin
      drive((c < 4) ? 2'b11 : 2'b00, 32'h400 + c*8, 32'h800 + c*8, 1'b1, c > 0,
            32'h1000 + c, 1'b0);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL rr_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      if (c < 4) begin
        n_checks++;
        if (bus.gnt !== exp_g[c]) $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_g[c]);
        else n_pass++;
      end
      if (c > 0) begin
        n_checks++;
        if (bus.rvalid !== exp_g[c-1])
          $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, bus.rvalid, exp_g[c-1]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_lock();
    obs_t e, o;
    for (int c = 0; c < 7; c++) begin
      drive((c == 0) ? 2'b01 : (c < 5) ? 2'b11 : 2'b00, 32'h0000_1006, 32'h0000_2008,
            c == 3 || c == 4, c >= 5, 32'h0, 1'b0);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL lock_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      if (c < 4) begin
        n_checks++;
        if (bus.instr_addr !== 32'h0000_1004 || bus.instr_req !== 1'b1)
          $display("FAIL lock_addr c=%0d got=%h exp=00001004", c, bus.instr_addr);
        else n_pass++;
      end
      if (c == 4) begin
        n_checks++;
        if (bus.gnt !== 2'b10 || bus.instr_addr !== 32'h0000_2008)
          $display("FAIL lock_next got=%b/%h exp=10/00002008", bus.gnt, bus.instr_addr);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    obs_t e, o;
    logic [5:0] exp_ireq = 6'b011011;  // bit c = expected instr_req in cycle c
    for (int c = 0; c < 8; c++) begin
      drive((c < 6) ? 2'b11 : 2'b00, 32'h3000, 32'h4000, 1'b1,
            c == 2 || c == 3 || c >= 6, 32'h55 + c, 1'b0);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL bp_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      if (c < 6) begin
        n_checks++;
        if (bus.instr_req !== exp_ireq[c])
          $display("FAIL bp_instr_req c=%0d got=%b exp=%b", c, bus.instr_req, exp_ireq[c]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_ordered();
    obs_t e, o;
    logic [1:0]  reqs [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
    logic [31:0] rd   [4] = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678};
    logic [1:0]  exp_v[4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    for (int c = 0; c < 4; c++) begin
      drive(reqs[c], 32'h5000, 32'h6000, 1'b1, c >= 2, rd[c], c == 3);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL ord_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      n_checks++;
      if (bus.rvalid !== exp_v[c] || bus.err !== (c == 3) || bus.rdata !== rd[c])
        $display("FAIL ord_rsp c=%0d got=%b/%b/%h exp=%b/%b/%h", c, bus.rvalid, bus.err,
                 bus.rdata, exp_v[c], c == 3, rd[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    obs_t        e, o;
    logic [31:0] ra [2];
    logic [1:0]  rq;
    ra[0] = $urandom; ra[1] = $urandom;
    for (int c = 0; c < 400; c++) begin
      rq = 2'($urandom_range(0, 3));
      if (m_lock) rq[m_lock_id] = 1'b1;
      drive(rq, ra[0], ra[1], $urandom_range(0, 99) < 60,
            (mq.size() > 0) && ($urandom_range(0, 99) < 50), $urandom, 1'($urandom_range(0, 1)));
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL rand_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      for (int k = 0; k < 2; k++) if (e.gnt[k]) ra[k] = $urandom;
      tick();
    end
  endtask

  task automatic test_drain();
    obs_t e, o;
    int   budget = 20;
    while ((mq.size() > 0 || m_lock) && budget > 0) begin
      drive(m_lock ? 2'(1 << m_lock_id) : 2'b00, 32'h7000, 32'h7100, 1'b1, mq.size() > 0,
            32'h0, 1'b0);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL drain_model got=%h exp=%h", o, e); else n_pass++;
      tick();
      budget--;
    end
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (busy_o !== 1'b0 || budget == 0) $display("FAIL drain_timeout busy=%b budget=%0d exp=0", busy_o, budget);
    else n_pass++;
  endtask

  task automatic test_spurious();
    obs_t e, o;
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 32'h0, 32'h0, 1'b0, c == 0, 32'hCAFE_0000 + c, 1'b0);
      e = m_exp(); o = dut_obs(); n_checks++;
      if (o !== e) $display("FAIL spur_model c=%0d got=%h exp=%h", c, o, e); else n_pass++;
      n_checks++;
      if ({bus.rvalid, busy_o, proto_err_o} !== {2'b00, 1'b0, c > 0})
        $display("FAIL spur_flags c=%0d got=%b exp=%b", c, {bus.rvalid, busy_o, proto_err_o},
                 {2'b00, 1'b0, c > 0});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    drive(2'b01, 32'h8000, 32'h9000, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'b10, 32'h8000, 32'h9000, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(2'b11, 32'h8000, 32'h9000, 1'b1, 1'b1, 32'h0, 1'b0);
    rst_ni = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if ({bus.instr_req, bus.gnt, bus.rvalid, busy_o, proto_err_o} !== 7'b0)
      $display("FAIL rstmid_forced got=%b exp=0000000",
               {bus.instr_req, bus.gnt, bus.rvalid, busy_o, proto_err_o});
    else n_pass++;
    tick();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_ni = 1'b1;
    tick();
    e = m_exp(); o = dut_obs(); n_checks++;
    if (o !== e) $display("FAIL rstmid_idle got=%h exp=%h", o, e); else n_pass++;
    drive(2'b11, 32'hA000, 32'hB000, 1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.gnt !== 2'b01 || bus.instr_addr !== 32'hA000)
      $display("FAIL rstmid_restart got=%b/%h exp=01/0000a000", bus.gnt, bus.instr_addr);
    else n_pass++;
    tick();
  endtask

  initial begin
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_ordered();
    test_random();
    test_drain();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
